// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing NUM_REGS word registers with byte strobes.
// Write path uses independent one-deep AW/W buffers; read path is a small latency FSM.
//
// state   | meaning
// RD_IDLE | ready for a read address, arready high
// RD_WAIT | counting down extra read latency
// RD_RESP | rdata/rresp held with rvalid high until rready
module axi4_lite_slave_regfile #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 16,
    parameter int READ_LATENCY = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_WIDTH - OFFS;
    localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W:0] NREGS    = (IDX_W + 1)'(NUM_REGS);
    localparam logic [3:0]     LAT_LOAD = 4'(READ_LATENCY - 1);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < NREGS;
    endfunction

    function automatic logic [RIDX_W-1:0] ridx(input logic [IDX_W-1:0] idx);
        return idx[RIDX_W-1:0];
    endfunction

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  aw_full, w_full;
    logic [IDX_W-1:0]      aw_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;
    logic                  aw_hs, w_hs, wr_commit, wr_ok;

    rd_state_t             state, state_nxt;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      ar_idx, rd_idx;
    logic                  ar_hs, rd_ok, rd_capture;
    logic [DATA_WIDTH-1:0] rd_word;

    // byte-offset address bits select nothing in a word-wide register file
    logic unused_offs;
    assign unused_offs = ^{awaddr[OFFS-1:0], araddr[OFFS-1:0]};

    assign awready   = aresetn & ~aw_full & ~bvalid;
    assign wready    = aresetn & ~w_full & ~bvalid;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign wr_commit = aw_full & w_full & ~bvalid;
    assign wr_ok     = idx_ok(aw_idx);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_idx  <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
        end else if (wr_commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_idx  <= awaddr[ADDR_WIDTH-1:OFFS];
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
            if (bvalid && bready)
                bvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_commit && wr_ok) begin
            for (int b = 0; b < STRB_W; b++)
                if (w_strb[b])
                    regs[ridx(aw_idx)][8*b +: 8] <= w_data[8*b +: 8];
        end
    end

    // Latency 0 captures straight from araddr on the AR handshake edge
    assign ar_hs      = arvalid & arready;
    assign rd_idx     = (state == RD_IDLE) ? araddr[ADDR_WIDTH-1:OFFS] : ar_idx;
    assign rd_ok      = idx_ok(rd_idx);
    assign rd_word    = rd_ok ? regs[ridx(rd_idx)] : '0;
    assign rd_capture = (state_nxt == RD_RESP) && (state != RD_RESP);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= RD_IDLE;
            cnt    <= '0;
            ar_idx <= '0;
            rdata  <= '0;
            rresp  <= RESP_OKAY;
        end else begin
            state <= state_nxt;
            if (ar_hs) begin
                cnt    <= LAT_LOAD;
                ar_idx <= araddr[ADDR_WIDTH-1:OFFS];
            end else if (state == RD_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (rd_capture) begin
                rdata <= rd_word;
                rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RD_IDLE: if (ar_hs) state_nxt = (READ_LATENCY == 0) ? RD_RESP : RD_WAIT;
            RD_WAIT: if (cnt == 4'd0) state_nxt = RD_RESP;
            RD_RESP: if (rready) state_nxt = RD_IDLE;
            default: state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        arready = aresetn & (state == RD_IDLE);
        rvalid  = (state == RD_RESP);
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
AXI4_LITE_SLAVE_REGFILE -- requirements
Module: axi4_lite_slave_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, 8, byte-address width of awaddr/araddr.
REQ-002 Parameter DATA_WIDTH, 32, data width; SHALL be 32 or 64.
REQ-003 Parameter NUM_REGS, 16, number of DATA_WIDTH-bit registers; 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
REQ-004 Parameter READ_LATENCY, 0, extra wait cycles between AR acceptance and rvalid; 0..15.
REQ-005 aclk  input  1  clock; all state changes on rising edge.
REQ-006 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-007 awvalid/awready  input/output  1/1  write-address handshake; awaddr  input  ADDR_WIDTH.
REQ-008 wvalid/wready  input/output  1/1  write-data handshake; wdata  input  DATA_WIDTH; wstrb  input  DATA_WIDTH/8.
REQ-009 bvalid/bready  output/input  1/1  write-response handshake; bresp  output  2.
REQ-010 arvalid/arready  input/output  1/1  read-address handshake; araddr  input  ADDR_WIDTH.
REQ-011 rvalid/rready  output/input  1/1  read-data handshake; rdata  output  DATA_WIDTH; rresp  output  2.

Function
REQ-012 Transfer on any channel SHALL occur only on an edge where valid and ready are both high.
REQ-013 Register index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-014 Index >= NUM_REGS SHALL give resp 2'b10 (SLVERR), no register change, rdata = 0; otherwise resp 2'b00 (OKAY).
REQ-015 AW and W SHALL be accepted independently into one-deep holding buffers, in either order or the same cycle.
REQ-016 awready = AW buffer empty AND bvalid low; wready = W buffer empty AND bvalid low (registered or combinational, no dependence on awvalid/wvalid).
REQ-017 When both buffers are full and bvalid is low, write SHALL commit on that edge: byte lane i updated iff wstrb[i]; both buffers cleared; bvalid high next cycle.
REQ-018 bvalid and bresp SHALL hold stable until bready; bvalid clears on the handshake edge; next AW/W accepted from the following cycle.
REQ-019 Read FSM states: IDLE, WAIT, RESP. arready high only in IDLE.
REQ-020 IDLE -> WAIT on AR handshake when READ_LATENCY > 0 (counter loaded READ_LATENCY-1); IDLE -> RESP directly when READ_LATENCY = 0.
REQ-021 WAIT decrements counter each cycle; -> RESP when counter is 0.
REQ-022 rdata/rresp SHALL be captured from the register array on the edge entering RESP (pre-write value if a write commits on that same edge); rvalid high in RESP.
REQ-023 rdata, rresp, rvalid SHALL hold stable in RESP until rready; RESP -> IDLE on handshake.
REQ-024 Read and write paths SHALL operate concurrently without mutual stall.
REQ-025 A write committed at least one edge before the read capture edge SHALL be visible in rdata.

Reset
REQ-026 aresetn low SHALL immediately force awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; all registers = 0; buffers empty; FSM IDLE.
REQ-027 First cycle after aresetn deasserts: awready, wready, arready = 1.
REQ-028 Reset mid-transaction SHALL discard all buffered/in-flight transfers with no response issued.

Verification
REQ-029 Write 0xDEADBEEF to addr 0x04, wstrb 0xF, AW and W same cycle -> bvalid 1 cycle later, bresp 0; read 0x04 -> rdata 0xDEADBEEF, rresp 0.
REQ-030 W 3 cycles before AW, wdata 0x000000AA, wstrb 0x1 to a reg holding 0x11223344 -> reg becomes 0x112233AA; awready/wready low while bvalid held 5 cycles with bready low.
REQ-031 Write and read to addr 0x40 (NUM_REGS=16, DATA_WIDTH=32) -> bresp 2'b10, rresp 2'b10, rdata 0, no register changed.
REQ-032 READ_LATENCY=3: AR handshake at edge N -> rvalid rises after edge N+3; rready held low 4 cycles -> rdata stable, arready low throughout.
REQ-033 Concurrent read of reg 2 and write of reg 2 committing on the RESP-entry edge -> old value returned; repeat read -> new value.
REQ-034 aresetn pulsed low while bvalid and rvalid high -> both drop immediately; subsequent read of any reg returns 0.
